// File: rtl/bcd_updown_chain_pkg.sv
// Shared constants and helpers for the cascaded BCD up/down counter.
package bcd_updown_chain_pkg;

   localparam int BCD_W      = 4;
   localparam int MAX_DIGITS = 8;

   // Digit i's maximum, taken from a zero-extended per-digit maximum vector.
   function automatic logic [BCD_W-1:0] digit_max(
      input logic [BCD_W*MAX_DIGITS-1:0] max_vec,
      input int                          i
   );
      return max_vec[i*BCD_W +: BCD_W];
   endfunction

endpackage

// File: rtl/bcd_updown_chain_bcd_digit.sv
// One BCD digit of the chain: clear, clamped load, and wrap-around up/down stepping.
module bcd_digit
   import bcd_updown_chain_pkg::*;
(
   input  logic             clk_out,
   input  logic             reset_n,
   input  logic             step_up,
   input  logic             step_dn,
   input  logic [BCD_W-1:0] max,
   input  logic             clr,
   input  logic             ld,
   input  logic [BCD_W-1:0] ld_val,
   output logic [BCD_W-1:0] val,
   output logic             at_max,
   output logic             at_zero
);

   // Loaded codes above the digit's maximum (including 10..15) land on the maximum.
   function automatic logic [BCD_W-1:0] clamp_digit(
      input logic [BCD_W-1:0] d,
      input logic [BCD_W-1:0] lim
   );
      return (d > lim) ? lim : d;
   endfunction

   assign at_max  = (val == max);
   assign at_zero = (val == '0);

   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         val <= '0;
      end else if (clr) begin
         val <= '0;
      end else if (ld) begin
         val <= clamp_digit(ld_val, max);
      end else if (step_up) begin
         val <= at_max ? '0 : val + BCD_W'(1);
      end else if (step_dn) begin
         val <= at_zero ? max : val - BCD_W'(1);
      end
   end

endmodule

// File: rtl/bcd_updown_chain.sv
// Cascaded BCD up/down counter with per-digit maxima, optional end saturation and
// registered over/borrow pulses.
module bcd_updown_chain
   import bcd_updown_chain_pkg::*;
#(
   parameter int                          NUM_DIGITS = 4,
   parameter logic [4*NUM_DIGITS-1:0]     DIGIT_MAX  = {4'd5, 4'd9, 4'd5, 4'd9},
   parameter bit                          SATURATE   = 1'b0
)(
   input  logic                        clk_out,
   input  logic                        reset_n,
   input  logic                        en,
   input  logic                        up,
   input  logic                        clr,
   input  logic                        load,
   input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
   output logic [BCD_W*NUM_DIGITS-1:0] value,
   output logic                        over,
   output logic                        borrow,
   output logic                        zero,
   output logic                        at_max
);

   localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_EXT = (BCD_W*MAX_DIGITS)'(DIGIT_MAX);

   logic [NUM_DIGITS-1:0] dig_max;
   logic [NUM_DIGITS-1:0] dig_zero;
   logic [NUM_DIGITS:0]   max_chain;
   logic [NUM_DIGITS:0]   zero_chain;
   logic                  all_max;
   logic                  all_zero;
   logic                  count_up;
   logic                  count_dn;
   logic                  hold_up;
   logic                  hold_dn;
   logic                  over_p1;
   logic                  borrow_p1;

   assign count_up = en &  up & ~clr & ~load;
   assign count_dn = en & ~up & ~clr & ~load;

   // Combinational carry/borrow chain: digit i steps once every lower digit is at its end.
   assign max_chain[0]  = 1'b1;
   assign zero_chain[0] = 1'b1;
   assign all_max       = max_chain[NUM_DIGITS];
   assign all_zero      = zero_chain[NUM_DIGITS];

   assign hold_up = SATURATE & all_max;
   assign hold_dn = SATURATE & all_zero;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      localparam logic [BCD_W-1:0] DMAX = digit_max(MAX_EXT, i);

      assign max_chain[i+1]  = max_chain[i]  & dig_max[i];
      assign zero_chain[i+1] = zero_chain[i] & dig_zero[i];

      bcd_digit u_digit (
         .clk_out (clk_out),
         .reset_n (reset_n),
         .step_up (count_up & max_chain[i]  & ~hold_up),
         .step_dn (count_dn & zero_chain[i] & ~hold_dn),
         .max     (DMAX),
         .clr     (clr),
         .ld      (load),
         .ld_val  (load_value[i*BCD_W +: BCD_W]),
         .val     (value[i*BCD_W +: BCD_W]),
         .at_max  (dig_max[i]),
         .at_zero (dig_zero[i])
      );
   end

   // Stage p1: end-of-range pulses, one cycle after the causing edge.
   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         over_p1   <= 1'b0;
         borrow_p1 <= 1'b0;
      end else begin
         over_p1   <= count_up & all_max;
         borrow_p1 <= count_dn & all_zero;
      end
   end

   assign over   = over_p1;
   assign borrow = borrow_p1;
   assign zero   = all_zero;
   assign at_max = all_max;

endmodule

// File: tb/tb_bcd_updown_chain.sv
// Directed bench for bcd_updown_chain: default wrap, saturating and two-digit builds.
module tb_bcd_updown_chain;

   logic        clk_out = 1'b0;
   logic        reset_n;
   logic        en, up, clr, load;
   logic [15:0] lv16;
   logic [7:0]  lv8;

   logic [15:0] d_value, s_value;
   logic [7:0]  n_value;
   logic        d_over, d_borrow, d_zero, d_at_max;
   logic        s_over, s_borrow, s_zero, s_at_max;
   logic        n_over, n_borrow, n_zero, n_at_max;

   int checks = 0;
   int fails  = 0;

   always #5 clk_out = ~clk_out;

   bcd_updown_chain u_def (
      .clk_out(clk_out), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_value(lv16), .value(d_value), .over(d_over), .borrow(d_borrow),
      .zero(d_zero), .at_max(d_at_max)
   );

   bcd_updown_chain #(.SATURATE(1'b1)) u_sat (
      .clk_out(clk_out), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_value(lv16), .value(s_value), .over(s_over), .borrow(s_borrow),
      .zero(s_zero), .at_max(s_at_max)
   );

   bcd_updown_chain #(.NUM_DIGITS(2), .DIGIT_MAX(8'h99)) u_two (
      .clk_out(clk_out), .reset_n(reset_n), .en(en), .up(up), .clr(clr), .load(load),
      .load_value(lv8), .value(n_value), .over(n_over), .borrow(n_borrow),
      .zero(n_zero), .at_max(n_at_max)
   );

   task automatic tick();
      @(posedge clk_out);
      #1;
   endtask

   function automatic logic [15:0] mmss(input int n);
      int s;
      s = n % 3600;
      return {4'((s / 600) % 6), 4'((s / 60) % 10), 4'((s / 10) % 6), 4'(s % 10)};
   endfunction

   task automatic test_reset();
      #3;
      checks++; if (d_value !== 16'h0000) begin fails++; $display("FAIL reset_value got=%h exp=0000", d_value); end
      checks++; if (d_over !== 1'b0 || d_borrow !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", d_over, d_borrow); end
      checks++; if (d_zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%b exp=1", d_zero); end
      checks++; if (d_at_max !== 1'b0) begin fails++; $display("FAIL reset_at_max got=%b exp=0", d_at_max); end
      load = 1'b1; lv16 = 16'h1234; en = 1'b1;
      tick();
      checks++; if (d_value !== 16'h0000) begin fails++; $display("FAIL reset_dominates got=%h exp=0000", d_value); end
      load = 1'b0; en = 1'b0; reset_n = 1'b1;
      tick();
      checks++; if (d_value !== 16'h0000) begin fails++; $display("FAIL reset_release got=%h exp=0000", d_value); end
   endtask

   task automatic test_load_clamp();
      lv16 = 16'h7F39; lv8 = 8'hA7; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (d_value !== 16'h5939) begin fails++; $display("FAIL load_clamp got=%h exp=5939", d_value); end
      checks++; if (s_value !== 16'h5939) begin fails++; $display("FAIL load_clamp_sat got=%h exp=5939", s_value); end
      checks++; if (n_value !== 8'h97) begin fails++; $display("FAIL load_clamp_two got=%h exp=97", n_value); end
      checks++; if (d_over !== 1'b0 || d_borrow !== 1'b0) begin fails++; $display("FAIL load_pulses got=%b%b exp=00", d_over, d_borrow); end
   endtask

   task automatic test_wrap_borrow();
      lv16 = 16'h0000; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      en = 1'b0;
      checks++; if (d_value !== 16'h5959) begin fails++; $display("FAIL borrow_wrap got=%h exp=5959", d_value); end
      checks++; if (d_borrow !== 1'b1 || d_over !== 1'b0) begin fails++; $display("FAIL borrow_pulse got=b%b o%b exp=b1 o0", d_borrow, d_over); end
      checks++; if (d_at_max !== 1'b1) begin fails++; $display("FAIL borrow_at_max got=%b exp=1", d_at_max); end
      checks++; if (s_value !== 16'h0000) begin fails++; $display("FAIL borrow_sat_hold got=%h exp=0000", s_value); end
      checks++; if (s_borrow !== 1'b1) begin fails++; $display("FAIL borrow_sat_pulse got=%b exp=1", s_borrow); end
      tick();
      checks++; if (d_borrow !== 1'b0 || s_borrow !== 1'b0) begin fails++; $display("FAIL borrow_one_cycle got=%b%b exp=00", d_borrow, s_borrow); end
      checks++; if (d_value !== 16'h5959) begin fails++; $display("FAIL borrow_hold got=%h exp=5959", d_value); end
   endtask

   task automatic test_two_digit();
      lv8 = 8'h99; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      en = 1'b0;
      checks++; if (n_value !== 8'h00) begin fails++; $display("FAIL two_wrap got=%h exp=00", n_value); end
      checks++; if (n_over !== 1'b1) begin fails++; $display("FAIL two_over got=%b exp=1", n_over); end
      tick();
      checks++; if (n_over !== 1'b0) begin fails++; $display("FAIL two_over_clear got=%b exp=0", n_over); end
   endtask

   task automatic test_priority();
      lv16 = 16'h1234; load = 1'b1;
      tick();
      checks++; if (d_value !== 16'h1234) begin fails++; $display("FAIL prio_setup got=%h exp=1234", d_value); end
      clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; lv16 = 16'h5959;
      tick();
      clr = 1'b0; load = 1'b0; en = 1'b0;
      checks++; if (d_value !== 16'h0000) begin fails++; $display("FAIL prio_clr got=%h exp=0000", d_value); end
      checks++; if (d_over !== 1'b0) begin fails++; $display("FAIL prio_clr_over got=%b exp=0", d_over); end
      lv16 = 16'h0100; load = 1'b1; en = 1'b1; up = 1'b0;
      tick();
      load = 1'b0; en = 1'b0;
      checks++; if (d_value !== 16'h0100) begin fails++; $display("FAIL prio_load got=%h exp=0100", d_value); end
   endtask

   task automatic test_direction();
      lv16 = 16'h0009; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      checks++; if (d_value !== 16'h0010) begin fails++; $display("FAIL dir_up got=%h exp=0010", d_value); end
      up = 1'b0;
      tick();
      checks++; if (d_value !== 16'h0009) begin fails++; $display("FAIL dir_switch got=%h exp=0009", d_value); end
      tick();
      checks++; if (d_value !== 16'h0008) begin fails++; $display("FAIL dir_down got=%h exp=0008", d_value); end
      en = 1'b0; lv16 = 16'h1000; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b0;
      tick();
      en = 1'b0;
      checks++; if (d_value !== 16'h0959) begin fails++; $display("FAIL dir_chain_borrow got=%h exp=0959", d_value); end
   endtask

   task automatic test_hold();
      repeat (3) tick();
      checks++; if (d_value !== 16'h0959) begin fails++; $display("FAIL hold_value got=%h exp=0959", d_value); end
      checks++; if (d_over !== 1'b0 || d_borrow !== 1'b0) begin fails++; $display("FAIL hold_pulses got=%b%b exp=00", d_over, d_borrow); end
   endtask

   task automatic test_async_reset();
      lv16 = 16'h5958; load = 1'b1;
      tick();
      load = 1'b0;
      #3 reset_n = 1'b0;
      #1;
      checks++; if (d_value !== 16'h0000) begin fails++; $display("FAIL async_value got=%h exp=0000", d_value); end
      checks++; if (d_zero !== 1'b1 || d_at_max !== 1'b0) begin fails++; $display("FAIL async_flags got=z%b m%b exp=z1 m0", d_zero, d_at_max); end
      #2 reset_n = 1'b1;
      lv16 = 16'h5959; load = 1'b1;
      tick();
      load = 1'b0; en = 1'b1; up = 1'b1;
      tick();
      en = 1'b0;
      checks++; if (d_over !== 1'b1) begin fails++; $display("FAIL async_pre_over got=%b exp=1", d_over); end
      #3 reset_n = 1'b0;
      #1;
      checks++; if (d_over !== 1'b0) begin fails++; $display("FAIL async_abandon_over got=%b exp=0", d_over); end
      #2 reset_n = 1'b1;
   endtask

   task automatic test_full_count();
      reset_n = 1'b0;
      #2 reset_n = 1'b1;
      en = 1'b1; up = 1'b1;
      for (int n = 1; n <= 3600; n++) begin
         tick();
         checks++;
         if (d_value !== mmss(n) || d_over !== (n == 3600)) begin
            fails++;
            $display("FAIL full_count step=%0d got=%h/%b exp=%h/%b", n, d_value, d_over, mmss(n), (n == 3600));
         end
      end
      en = 1'b0;
      checks++; if (s_value !== 16'h5959 || s_over !== 1'b1) begin fails++; $display("FAIL full_sat got=%h/%b exp=5959/1", s_value, s_over); end
      tick();
      checks++; if (d_over !== 1'b0 || d_value !== 16'h0000) begin fails++; $display("FAIL full_after got=%h/%b exp=0000/0", d_value, d_over); end
   endtask

   initial begin
      reset_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0;
      lv16 = '0; lv8 = '0;
      test_reset();
      test_load_clamp();
      test_wrap_borrow();
      test_two_digit();
      test_priority();
      test_direction();
      test_hold();
      test_async_reset();
      test_full_count();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/bcd_updown_chain.md
BCD_UPDOWN_CHAIN -- requirements
Module: bcd_updown_chain

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 4, giving the number of cascaded decimal digits (range 1..8).
REQ-002 The block SHALL have parameter DIGIT_MAX, a 4*NUM_DIGITS vector, default {4'd5,4'd9,4'd5,4'd9}, giving the per-digit maximum; digit 0 is least significant, and each entry is in the range 1..9.
REQ-003 The block SHALL have parameter SATURATE, default 0, where 0 means wrap at the ends and 1 means hold at the ends.
REQ-004 The block SHALL have port clk_out, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: count enable, sampled each clock.
REQ-007 The block SHALL have port up, input, 1 bit: count direction, 1 = increment and 0 = decrement.
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear to all-zero.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous parallel load.
REQ-010 The block SHALL have port load_value, input, 4*NUM_DIGITS bits: the BCD load data.
REQ-011 The block SHALL have port value, output, 4*NUM_DIGITS bits: the registered BCD count.
REQ-012 The block SHALL have port over, output, 1 bit: registered one-cycle pulse on an up-count attempted at the all-max state.
REQ-013 The block SHALL have port borrow, output, 1 bit: registered one-cycle pulse on a down-count attempted at the all-zero state.
REQ-014 The block SHALL have port zero, output, 1 bit: combinational, high when value is all-zero.
REQ-015 The block SHALL have port at_max, output, 1 bit: combinational, high when every digit equals its DIGIT_MAX entry.

Function
REQ-016 Per-edge priority SHALL be clr, then load, then count (en), then hold.
REQ-017 clr SHALL set value to 0 and force over and borrow to 0 on the next edge.
REQ-018 load SHALL write load_value digit by digit, clamping any digit above its DIGIT_MAX entry (including non-BCD codes 10..15) to that DIGIT_MAX entry; over and borrow SHALL be 0.
REQ-019 Up-counting with en=1 SHALL increment digit 0, and digit i SHALL step only when all lower digits equal their max; a digit at its max SHALL roll to 0.
REQ-020 Down-counting with en=1 SHALL decrement digit 0, and digit i SHALL step only when all lower digits are 0; a digit at 0 SHALL roll to its max.
REQ-021 An up-count at all-max SHALL produce value = 0 with over=1 when SATURATE=0, and SHALL hold value with over=1 when SATURATE=1.
REQ-022 A down-count at all-zero SHALL produce value = all-max with borrow=1 when SATURATE=0, and SHALL hold value with borrow=1 when SATURATE=1.
REQ-023 over and borrow SHALL be high for exactly the one cycle following the causing edge, SHALL never both be high, and SHALL be 0 otherwise.
REQ-024 Count latency SHALL be one edge: value reflects en/up sampled at edge k immediately after edge k.
REQ-025 When en=0 and load=0 and clr=0, value SHALL hold and over and borrow SHALL be 0.
REQ-026 A direction change between consecutive enabled cycles SHALL take effect immediately, with no extra latency.
REQ-027 Non-BCD digit values SHALL be unreachable except through an unclamped path, and no such path SHALL exist.

Reset
REQ-028 reset_n low SHALL asynchronously force value=0, over=0 and borrow=0, independent of all other inputs.
REQ-029 While reset_n is low, zero SHALL be 1 and at_max SHALL be 0.
REQ-030 Reset release SHALL be synchronised by the integrator; the first active edge after release SHALL obey REQ-016.
REQ-031 Reset asserted mid-count SHALL abandon any pending over or borrow pulse.

Structure
REQ-032 A shared package SHALL hold the constant BCD_W=4 and a function that extracts digit i's max from DIGIT_MAX.
REQ-033 The block SHALL use one sub-module, bcd_digit, instantiated NUM_DIGITS times, holding one 4-bit digit with inputs step_up, step_dn, max, clr, ld, ld_val and outputs val, at_max and at_zero.
REQ-034 Chain enables SHALL be derived combinationally from the lower digits' at_max or at_zero flags, with no ripple through registers.

Verification
REQ-035 Defaults: reset, then en=1 and up=1 for 3600 cycles -> value passes 59:59 (0x5959), then 0x0000 with over=1 for one cycle.
REQ-036 Defaults: load 0x0000, en=1, up=0 for 1 cycle -> value=0x5959 and borrow=1; with SATURATE=1 -> value=0x0000 and borrow=1.
REQ-037 Load 0x7F39 -> value=0x5939, clamped per digit.
REQ-038 clr, load and en all asserted in the same cycle with value=0x1234 -> value=0x0000 and over=0.
REQ-039 Assert reset_n low mid-cycle at value=0x5958 -> value=0 immediately, with no clock edge.
REQ-040 NUM_DIGITS=2 with DIGIT_MAX={9,9}: load 0x99, up-count 1 cycle -> value=0x00 and over=1.
